ro_meter: RTL and testbench

Ring-oscillator frequency meter for sub-threshold cell characterization. It enables an on-die oscillator chain built from the INVX1/NAND2X1/NOR2X1 library cells and synchronizes the chain's free-running output into the `clk` domain. It then counts the oscillator's rising edges over a programmable window of `clk` cycles and hands the count downstream over a valid/ready handshake. It sits directly downstream of the cell chain under test and upstream of the measurement readout/scan logic.

---
 rtl/ro_meter.sv | 120 ++++++++++++
 tb/tb_ro_meter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_meter.sv
// rtl/ro_meter.sv - ring-oscillator frequency meter: counts synchronized ro_in rising edges over a clk window
// Optional continuous mode (HOLD -> COUNT without SETTLE) is enabled by defining RO_METER_CONT_EN.
module ro_meter #(
   parameter int WIN_W      = 16,
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             ro_in,
   output logic             ro_en,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             count_vld,
   input  logic             count_rdy
);

   localparam int SET_W = $clog2(SETTLE_CYC);
   localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} state_t;

   state_t             state, state_nx;
   logic               ro_s1, ro_s2, ro_hist;
   logic               edge_det;
   logic [WIN_W-1:0]   win_q;
   logic [TMR_W-1:0]   tmr;
   logic               accept, restart;

   assign edge_det = ro_s2 & ~ro_hist;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      restart  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (tmr == '0) state_nx = (win_q == '0) ? HOLD : COUNT;
         end
         COUNT: begin
            if (tmr == '0) state_nx = HOLD;
         end
         HOLD: begin
            if (count_vld && count_rdy) begin
`ifdef RO_METER_CONT_EN
               if (start) begin
                  restart  = 1'b1;
                  state_nx = (win_q == '0) ? HOLD : COUNT;
               end else begin
                  state_nx = IDLE;
               end
`else
               state_nx = IDLE;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         ro_s1     <= 1'b0;
         ro_s2     <= 1'b0;
         ro_hist   <= 1'b0;
         win_q     <= '0;
         tmr       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         ro_en     <= 1'b0;
         busy      <= 1'b0;
         count_vld <= 1'b0;
      end else begin
         state     <= state_nx;
         ro_s1     <= ro_in;
         ro_s2     <= ro_s1;
         ro_hist   <= ro_s2;
         ro_en     <= (state_nx == SETTLE) || (state_nx == COUNT);
         busy      <= (state_nx != IDLE);
         count_vld <= (state_nx == HOLD);
         if (accept) begin
            win_q <= win_len;
            tmr   <= SETTLE_LOAD;
            count <= '0;
            ovf   <= 1'b0;
         end else if (restart) begin
            tmr   <= TMR_W'(win_q) - TMR_W'(1);
            count <= '0;
            ovf   <= 1'b0;
         end else begin
            if (state == SETTLE || state == COUNT) begin
               if (state == SETTLE && tmr == '0)
                  tmr <= TMR_W'(win_q) - TMR_W'(1);
               else
                  tmr <= tmr - TMR_W'(1);
            end
            if (state == COUNT && edge_det) begin
               if (count == CNT_MAX)
                  ovf <= 1'b1;
               else
                  count <= count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ro_meter.sv
// tb/tb_ro_meter.sv - self-checking bench for ro_meter: vector table, random windows vs edge model, corner sequences
module tb_ro_meter;

   localparam int S = 4;

   logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, ro_in = 1'b0, count_rdy = 1'b1;
   logic        start2 = 1'b0;
   logic [15:0] win_len = '0, win_len2 = '0;
   logic        ro_en, busy, ovf, count_vld;
   logic        ro_en2, busy2, ovf2, vld2;
   logic [15:0] count;
   logic [3:0]  count2;

   int total = 0, bad = 0, cyc = 0;
   int ro_mode = 0, ro_per = 4, run = 0;
   bit ro_log [0:65535];

   ro_meter #(.WIN_W(16), .CNT_W(16), .SETTLE_CYC(S)) dut (
      .clk(clk), .rstn(rstn), .start(start), .win_len(win_len), .ro_in(ro_in),
      .ro_en(ro_en), .busy(busy), .count(count), .ovf(ovf),
      .count_vld(count_vld), .count_rdy(count_rdy));

   ro_meter #(.WIN_W(16), .CNT_W(4), .SETTLE_CYC(S)) u_small (
      .clk(clk), .rstn(rstn), .start(start2), .win_len(win_len2), .ro_in(ro_in),
      .ro_en(ro_en2), .busy(busy2), .count(count2), .ovf(ovf2),
      .count_vld(vld2), .count_rdy(1'b1));

   always #5 clk = ~clk;

   // Oscillator source: value for cycle c is driven 1 time unit after edge c and logged.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (ro_mode == 0) begin
            ro_in = ((cyc / (ro_per / 2)) % 2) != 0;
         end else if (run >= 2 && $urandom_range(2) == 0) begin
            ro_in = ~ro_in;
            run = 1;
         end else begin
            run++;
         end
         ro_log[cyc] = ro_in;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_tol(input string nm, input longint act, input longint exp, input longint tol);
      total++;
      if (act < exp - tol || act > exp + tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d+-%0d", nm, act, exp, tol);
      end
   endtask

   // Rising edges whose detection cycle (2 cycles after the sample) lands in the COUNT window.
   function automatic int edges(input int k, input int n);
      int e = 0;
      for (int c = k + S - 1; c <= k + S + n - 2; c++)
         if (!ro_log[c-1] && ro_log[c]) e++;
      return e;
   endfunction

   task automatic meas(input int win, output int cnt, output int ov, output int lat,
                       output int en_cyc, output int mdl);
      int k;
      k = cyc;
      start = 1'b1;
      win_len = 16'(win);
      @(posedge clk);
      #1;
      start = 1'b0;
      win_len = 16'($urandom);
      lat = -1;
      en_cyc = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (ro_en) en_cyc++;
         if (count_vld) begin
            lat = cyc - k;
            break;
         end
      end
      cnt = int'(count);
      ov  = int'(ovf);
      mdl = edges(k, win);
   endtask

   task automatic hs_done(input string nm);
      @(posedge clk);
      #1;
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_vld"}, count_vld, 0);
   endtask

   typedef struct {
      int win;
      int per;
      int exp_cnt;
      int exp_lat;
      int exp_en;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int cnt, ov, lat, en, mdl, k, c0, w;

      tbl = '{'{100, 4, 25, 105, 104},
              '{0,   4, 0,  5,   4},
              '{40,  8, 5,  45,  44},
              '{16,  4, 4,  21,  20},
              '{64, 16, 4,  69,  68}};

      repeat (3) @(negedge clk);
      chk("reset_outs", {ro_en, busy, count_vld, ovf, count}, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         ro_mode = 0;
         ro_per = tbl[i].per;
         meas(tbl[i].win, cnt, ov, lat, en, mdl);
         chk("tbl_lat", lat, tbl[i].exp_lat);
         chk("tbl_en", en, tbl[i].exp_en);
         chk_tol("tbl_cnt", cnt, tbl[i].exp_cnt, 1);
         chk("tbl_model", cnt, mdl);
         chk("tbl_ovf", ov, 0);
         hs_done("tbl_hs");
      end

      ro_mode = 1;
      for (int i = 0; i < 8; i++) begin
         w = $urandom_range(60);
         repeat ($urandom_range(3)) @(posedge clk);
         #1;
         meas(w, cnt, ov, lat, en, mdl);
         chk("rnd_lat", lat, w + S + 1);
         chk("rnd_model", cnt, mdl);
         chk("rnd_ovf", ov, 0);
         hs_done("rnd_hs");
      end

      // Saturation on the 4-bit instance.
      ro_mode = 0;
      ro_per = 4;
      start2 = 1'b1;
      win_len2 = 16'd200;
      @(posedge clk);
      #1 start2 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (vld2) break;
      end
      chk("sat_vld", vld2, 1);
      chk("sat_cnt", count2, 15);
      chk("sat_ovf", ovf2, 1);
      @(posedge clk);
      #1;

      // Backpressure in HOLD with start pulses ignored.
      ro_per = 8;
      count_rdy = 1'b0;
      meas(30, cnt, ov, lat, en, mdl);
      chk("hold_model", cnt, mdl);
      c0 = cnt;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         start = 1'($urandom);
         win_len = 16'($urandom);
         @(negedge clk);
         chk("hold_vld", count_vld, 1);
         chk("hold_cnt", count, c0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      count_rdy = 1'b1;
      hs_done("hold_hs");
      @(posedge clk);
      #1;
      chk("hold_no_new", busy, 0);

      // Asynchronous reset in COUNT cycle 50.
      ro_per = 4;
      k = cyc;
      start = 1'b1;
      win_len = 16'd200;
      @(posedge clk);
      #1 start = 1'b0;
      while (cyc < k + S + 50) @(posedge clk);
      #3;
      chk("pre_rst_busy", busy, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_outs", {ro_en, busy, count_vld, ovf, count}, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_idle", {ro_en, busy, count_vld}, 0);
      @(posedge clk);
      #1;

`ifdef RO_METER_CONT_EN
      begin
         int prev, got;
         prev = -1;
         ro_per = 8;
         start = 1'b1;
         win_len = 16'd40;
         for (int r = 0; r < 3; r++) begin
            got = -1;
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (count_vld) begin
                  got = cyc;
                  break;
               end
            end
            chk_tol("cont_cnt", count, 5, 1);
            if (prev >= 0) chk("cont_gap", got - prev, 41);
            prev = got;
         end
         @(posedge clk);
         #1 start = 1'b0;
         repeat (60) @(negedge clk);
         chk("cont_idle", busy, 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
